pipe_add_sub: RTL and testbench

- Parametrised, pipelined ripple-chunk adder/subtractor.
- Splits a WIDTH-bit add/sub into STAGES = WIDTH/STAGE_W chunks. Each chunk is one pipeline stage, and the carry is registered between stages.
- Accepts one operation per cycle through a valid/ready handshake.
- Provides carry-out and signed overflow.
- Successor to the team's fixed 5-bit ripple adder, for wide datapaths where a full-width carry chain misses timing.

---
 rtl/pipe_add_sub.sv | 94 +++++++++
 tb/tb_pipe_add_sub.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_add_sub.sv
// Pipelined ripple-chunk adder/subtractor: each STAGE_W-bit slice of X + Yeff + sub
// is summed in its own pipeline stage, with the slice carry registered between stages.
module pipe_add_sub #(
    parameter int WIDTH   = 16,
    parameter int STAGE_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] X,
    input  logic [WIDTH-1:0] Y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             Ov
);
    localparam int STAGES = WIDTH / STAGE_W;
    localparam int LAST   = STAGES - 1;
    localparam int PW     = STAGES * WIDTH;

    logic [STAGES-1:0][WIDTH-1:0] x_q, x_d, y_q, y_d, sum_q, sum_d;
    logic [STAGES-1:0]            valid_q, valid_d, carry_q, carry_d;
    logic                         ov_q, ov_d;

    logic [STAGES-1:0][WIDTH-1:0] x_fwd, y_fwd, sum_fwd;
    logic [STAGES-1:0]            valid_fwd, carry_fwd;
    logic [WIDTH-1:0]             y_eff;
    logic [STAGE_W:0]             chunk;
    logic                         stall;

    assign stall    = valid_q[LAST] && !out_ready;
    assign in_ready = !stall;
    assign y_eff    = sub ? ~Y : Y;

    // Entry k is what stage k consumes: the ports for stage 0, otherwise stage k-1's registers.
    assign x_fwd     = (x_q << WIDTH) | PW'(X);
    assign y_fwd     = (y_q << WIDTH) | PW'(y_eff);
    assign sum_fwd   = sum_q << WIDTH;
    assign valid_fwd = (valid_q << 1) | STAGES'(in_valid);
    assign carry_fwd = (carry_q << 1) | STAGES'(sub);

    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ov_d    = ov_q;
        chunk   = '0;
        valid_d = stall ? valid_q : valid_fwd;
        for (int k = 0; k < STAGES; k++) begin
            chunk = {1'b0, STAGE_W'(x_fwd[k] >> (k * STAGE_W))}
                  + {1'b0, STAGE_W'(y_fwd[k] >> (k * STAGE_W))}
                  + (STAGE_W + 1)'(carry_fwd[k]);
            // Data registers only load behind a valid op, so outputs keep their last result.
            if (!stall && valid_fwd[k]) begin
                x_d[k]                          = x_fwd[k];
                y_d[k]                          = y_fwd[k];
                sum_d[k]                        = sum_fwd[k];
                sum_d[k][k * STAGE_W +: STAGE_W] = chunk[STAGE_W-1:0];
                carry_d[k]                      = chunk[STAGE_W];
            end
        end
        if (!stall && valid_fwd[LAST]) begin
            ov_d = (x_fwd[LAST][WIDTH-1] == y_fwd[LAST][WIDTH-1])
                && (sum_d[LAST][WIDTH-1] != x_fwd[LAST][WIDTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            valid_q <= '0;
            ov_q    <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            ov_q    <= ov_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign S         = sum_q[LAST];
    assign Co        = carry_q[LAST];
    assign Ov        = ov_q;
endmodule

// File: tb/tb_pipe_add_sub.sv
// Bench for pipe_add_sub: directed vectors, backpressure and reset sequences on a 16/4 instance,
// plus random traffic on four parameter sets checked against a latency/arithmetic reference model.
module tb_pipe_add_sub;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, sub, out_valid, out_ready, co, ov;
    logic [15:0] x, y, s;

    int n_checks = 0;
    int n_errors = 0;
    bit sweep_done [4];

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    always #5 clk = ~clk;

    pipe_add_sub #(.WIDTH(16), .STAGE_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sub(sub),
        .X(x), .Y(y), .out_valid(out_valid), .out_ready(out_ready), .S(s), .Co(co), .Ov(ov)
    );

    function automatic void check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Plain integer arithmetic: unsigned wrap for S, unsigned compare for Co, signed range for Ov.
    function automatic void ref_op(input int w, input longint unsigned a, input longint unsigned b,
                                   input bit is_sub, output longint unsigned rs, output bit rco,
                                   output bit rov);
        longint unsigned modv = 64'd1 << w;
        longint          half = longint'(modv / 2);
        longint          sa   = (a >= modv / 2) ? longint'(a) - longint'(modv) : longint'(a);
        longint          sbv  = (b >= modv / 2) ? longint'(b) - longint'(modv) : longint'(b);
        longint          r;
        rs  = (is_sub ? a - b : a + b) & (modv - 1);
        rco = is_sub ? (a >= b) : ((a + b) >= modv);
        r   = is_sub ? sa - sbv : sa + sbv;
        rov = (r >= half) || (r < -half);
    endfunction

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        in_valid  = 1'b1;
        x         = v.x;
        y         = v.y;
        sub       = v.sub;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid  = 1'b0;
        x         = '0;
        y         = '0;
        sub       = 1'b0;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        @(negedge clk);
        @(negedge clk);
        check_val($sformatf("vec%0d out_valid before latency", idx), out_valid, 1'b0);
        @(negedge clk);
        check_val($sformatf("vec%0d out_valid", idx), out_valid, 1'b1);
        check_val($sformatf("vec%0d S", idx), s, v.s);
        check_val($sformatf("vec%0d Co", idx), co, v.co);
        check_val($sformatf("vec%0d Ov", idx), ov, v.ov);
        @(negedge clk);
        check_val($sformatf("vec%0d out_valid one cycle", idx), out_valid, 1'b0);
    endtask

    initial begin
        vec_t            vecs [11];
        logic [15:0]     bp_x [6];
        logic [15:0]     bp_y [6];
        bit              bp_sub [6];
        longint unsigned bp_s [6];
        bit              bp_co [6];
        bit              bp_ov [6];
        int              n_sent, n_recv, stall_left, stall_cycles;
        bit              stall_seen, will_acc;

        vecs[0]  = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'hFFFE, 1'b1, 1'b0};
        vecs[4]  = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[5]  = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[6]  = '{16'h0007, 16'h0007, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[8]  = '{16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        vecs[9]  = '{16'h0FFF, 16'h0001, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[10] = '{16'h7FFF, 16'hFFFF, 1'b1, 16'h8000, 1'b0, 1'b1};

        rst_n = 1'b1; in_valid = 1'b0; sub = 1'b0; x = '0; y = '0; out_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        check_val("reset out_valid", out_valid, 1'b0);
        check_val("reset S", s, 16'h0000);
        check_val("reset Co", co, 1'b0);
        check_val("reset Ov", ov, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("idle in_ready", in_ready, 1'b1);
            check_val("idle out_valid", out_valid, 1'b0);
        end

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], i);
        end

        // Six back-to-back ops; the sink refuses three cycles once the first result shows.
        for (int i = 0; i < 6; i++) begin
            bp_x[i]   = 16'($urandom);
            bp_y[i]   = 16'($urandom);
            bp_sub[i] = i[0];
            ref_op(16, bp_x[i], bp_y[i], bp_sub[i], bp_s[i], bp_co[i], bp_ov[i]);
        end
        n_sent = 0; n_recv = 0; stall_left = 0; stall_cycles = 0; stall_seen = 0; will_acc = 0;
        for (int cyc = 0; cyc < 60 && n_recv < 6; cyc++) begin
            @(negedge clk);
            if (will_acc) n_sent++;
            if (!stall_seen && out_valid) begin
                stall_seen = 1;
                stall_left = 3;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            in_valid = (n_sent < 6);
            if (n_sent < 6) begin
                x   = bp_x[n_sent];
                y   = bp_y[n_sent];
                sub = bp_sub[n_sent];
            end
            #1;
            if (out_valid) begin
                check_val($sformatf("bp%0d S", n_recv), s, bp_s[n_recv]);
                check_val($sformatf("bp%0d Co", n_recv), co, bp_co[n_recv]);
                check_val($sformatf("bp%0d Ov", n_recv), ov, bp_ov[n_recv]);
                if (out_ready) n_recv++;
                else begin
                    stall_cycles++;
                    check_val("bp in_ready during stall", in_ready, 1'b0);
                end
            end
            will_acc = in_valid && in_ready;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check_val("bp results received", n_recv, 6);
        check_val("bp stall cycles", stall_cycles, 3);
        repeat (4) begin
            @(negedge clk);
            check_val("bp no duplicate", out_valid, 1'b0);
        end

        // Reset lands between edges with one result showing and three ops still in flight.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x        = (i == 0) ? 16'hFFFF : 16'h1234 + 16'(i);
            y        = 16'hFFFF;
            sub      = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check_val("pre-reset out_valid", out_valid, 1'b1);
        check_val("pre-reset S", s, 16'hFFFE);
        #1 rst_n = 1'b0;
        #1;
        check_val("async reset out_valid", out_valid, 1'b0);
        check_val("async reset S", s, 16'h0000);
        check_val("async reset Co", co, 1'b0);
        check_val("async reset Ov", ov, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_val("post-reset out_valid", out_valid, 1'b0);
            check_val("post-reset in_ready", in_ready, 1'b1);
        end

        for (int c = 0; c < 3000; c++) begin
            if (sweep_done[0] && sweep_done[1] && sweep_done[2] && sweep_done[3]) break;
            @(posedge clk);
        end
        n_checks++;
        if (!(sweep_done[0] && sweep_done[1] && sweep_done[2] && sweep_done[3])) begin
            n_errors++;
            $display("[TB] FAIL sweep_timeout: sweeps not finished, required all four done");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Random traffic per parameter set; each accepted op waits STAGES unstalled edges.
    for (genvar g = 0; g < 4; g++) begin : g_sweep
        localparam int W  = (g == 0) ? 16 : (g == 1) ? 5 : (g == 2) ? 8 : 32;
        localparam int SW = (g == 0) ? 4 : (g == 1) ? 5 : (g == 2) ? 1 : 8;
        localparam int ST = W / SW;

        logic            r_n, iv, ir, sb, ovd, ordy, c_o, o_v;
        logic [W-1:0]    xa, yb, sum;
        longint unsigned q_s [$];
        bit              q_co [$];
        bit              q_ov [$];
        int              q_rem [$];

        pipe_add_sub #(.WIDTH(W), .STAGE_W(SW)) u_dut (
            .clk(clk), .rst_n(r_n), .in_valid(iv), .in_ready(ir), .sub(sb),
            .X(xa), .Y(yb), .out_valid(ovd), .out_ready(ordy), .S(sum), .Co(c_o), .Ov(o_v)
        );

        initial begin
            bit              head_done, stall;
            longint unsigned es;
            bit              eco, eov;
            r_n = 1'b1; iv = 1'b0; sb = 1'b0; xa = '0; yb = '0; ordy = 1'b0;
            #1 r_n = 1'b0;
            repeat (2) @(negedge clk);
            r_n = 1'b1;
            for (int cyc = 0; cyc < 600; cyc++) begin
                @(negedge clk);
                head_done = (q_rem.size() > 0) && (q_rem[0] == 0);
                check_val($sformatf("sweep%0d out_valid", g), ovd, head_done);
                check_val($sformatf("sweep%0d in_ready", g), ir, !(head_done && !ordy));
                if (head_done) begin
                    check_val($sformatf("sweep%0d S", g), sum, q_s[0]);
                    check_val($sformatf("sweep%0d Co", g), c_o, q_co[0]);
                    check_val($sformatf("sweep%0d Ov", g), o_v, q_ov[0]);
                end
                ordy = (cyc >= 560) || ($urandom_range(0, 3) != 0);
                stall = head_done && !ordy;
                iv   = !stall && (cyc < 560) && ($urandom_range(0, 9) < 7);
                sb   = 1'($urandom);
                xa   = ($urandom_range(0, 4) == 0) ? '1 : W'({$urandom, $urandom});
                yb   = ($urandom_range(0, 4) == 0) ? '1 : W'({$urandom, $urandom});
                if (!stall) begin
                    if (head_done) begin
                        void'(q_s.pop_front());
                        void'(q_co.pop_front());
                        void'(q_ov.pop_front());
                        void'(q_rem.pop_front());
                    end
                    for (int i = 0; i < q_rem.size(); i++)
                        if (q_rem[i] > 0) q_rem[i] = q_rem[i] - 1;
                    if (iv) begin
                        ref_op(W, longint'(xa), longint'(yb), sb, es, eco, eov);
                        q_s.push_back(es);
                        q_co.push_back(eco);
                        q_ov.push_back(eov);
                        q_rem.push_back(ST - 1);
                    end
                end
            end
            iv = 1'b0;
            sweep_done[g] = 1'b1;
        end
    end
endmodule
